// File: rtl/uart_tx_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_tick
//  Description : Serial UART transmitter paced by a divided clock.
//                div_clk_i is never used as a clock: a rising-edge detector
//                in the clk_i domain turns it into a one-cycle bit tick.
//                Bytes are accepted on a valid/ready handshake and shifted
//                out LSB-first as start / data / [parity] / stop frames.
//
//  Ports       : clk_i      in   system clock, all logic on posedge
//                rst_i      in   asynchronous, active-high reset
//                div_clk_i  in   divided clock (bit-rate source), sync to clk_i
//                data_i     in   payload, sampled on handshake
//                valid_i    in   data_i valid
//                ready_o    out  1 = idle, a frame can be accepted
//                tx_o       out  serial line, idle high
//                busy_o     out  1 = frame pending or in progress
//                done_o     out  one-cycle pulse when the last stop bit ends
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_tick #(
    parameter int DATA_BITS  = 8,   // payload bits per frame (5..9)
    parameter int PARITY_EN  = 0,   // 1 = append parity bit after data
    parameter int PARITY_ODD = 0,   // 1 = odd parity, 0 = even parity
    parameter int STOP_BITS  = 1    // 1 or 2 stop bits
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 div_clk_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    // Index of the last data bit; the DATA state leaves when bit_cnt hits it.
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    // Terminal value of the one-bit stop counter.
    localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]           state;
    logic                 div_clk_q;
    logic                 tick;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic                 parity_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 tx_q;
    logic                 done_q;

    // ------------------------------------------------------------------------
    // Bit-rate tick: one clk_i cycle per rising edge of div_clk_i.
    // A spurious tick right after reset release (div_clk_i already high)
    // lands in IDLE, which ignores ticks.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_clk_q <= 1'b0;
        end else begin
            div_clk_q <= div_clk_i;
        end
    end

    assign tick = div_clk_i & ~div_clk_q;

    // ------------------------------------------------------------------------
    // Parity of the incoming word, latched at acceptance so the payload may
    // change as soon as the handshake completes.
    // ------------------------------------------------------------------------
    generate
        if (PARITY_EN != 0) begin : g_parity
            if (PARITY_ODD != 0) begin : g_odd
                assign parity_next = ~^data_i;
            end else begin : g_even
                assign parity_next = ^data_i;
            end
        end else begin : g_no_parity
            assign parity_next = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Frame sequencer. Apart from IDLE->WAIT every transition is tick-gated,
    // so each line level lasts exactly one tick interval and a frozen
    // div_clk_i freezes the whole frame in place. The WAIT state aligns the
    // start edge to the first tick after acceptance and provides the one
    // tick gap between back-to-back frames.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Ticks are deliberately ignored here, including one
                    // coinciding with the accepting edge.
                    if (valid_i) begin
                        shreg      <= data_i;
                        parity_bit <= parity_next;
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (tick) begin
                        tx_q  <= 1'b0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        tx_q    <= shreg[0];
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_q  <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx_q     <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            // shreg[1] is the bit that becomes shreg[0]
                            // after this shift.
                            tx_q    <= shreg[1];
                            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: handshake flags decode the state register only.
    // ------------------------------------------------------------------------
    assign ready_o = (state == ST_IDLE);
    assign busy_o  = ~ready_o;
    assign tx_o    = tx_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_tick.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_tick
//  Description : Directed self-checking bench for uart_tx_tick. Four
//                instances share clock, reset and the divided clock:
//                defaults, even parity, odd parity, and two stop bits.
//                The divided clock has an 8-cycle period and can be frozen.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_tick;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic div_freeze = 1'b0;
    logic [2:0] div_cnt = 3'd0;
    logic div_clk;
    logic div_q_tb = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!div_freeze) div_cnt <= div_cnt + 3'd1;
        div_q_tb <= div_clk;
    end
    assign div_clk = div_cnt[2];

    // default instance
    logic [7:0] data_d = 8'h00;
    logic       valid_d = 1'b0;
    logic       ready_d, tx_d, busy_d, done_d;
    // parity instances (shared stimulus)
    logic [7:0] data_p = 8'h00;
    logic       valid_p = 1'b0;
    logic       ready_pe, tx_pe, busy_pe, done_pe;
    logic       ready_po, tx_po, busy_po, done_po;
    // two-stop-bit instance
    logic [7:0] data_s = 8'h00;
    logic       valid_s = 1'b0;
    logic       ready_s, tx_s, busy_s, done_s;

    uart_tx_tick u_def (
        .clk_i(clk), .rst_i(rst), .div_clk_i(div_clk),
        .data_i(data_d), .valid_i(valid_d),
        .ready_o(ready_d), .tx_o(tx_d), .busy_o(busy_d), .done_o(done_d)
    );

    uart_tx_tick #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
        .clk_i(clk), .rst_i(rst), .div_clk_i(div_clk),
        .data_i(data_p), .valid_i(valid_p),
        .ready_o(ready_pe), .tx_o(tx_pe), .busy_o(busy_pe), .done_o(done_pe)
    );

    uart_tx_tick #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
        .clk_i(clk), .rst_i(rst), .div_clk_i(div_clk),
        .data_i(data_p), .valid_i(valid_p),
        .ready_o(ready_po), .tx_o(tx_po), .busy_o(busy_po), .done_o(done_po)
    );

    uart_tx_tick #(.STOP_BITS(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .div_clk_i(div_clk),
        .data_i(data_s), .valid_i(valid_s),
        .ready_o(ready_s), .tx_o(tx_s), .busy_o(busy_s), .done_o(done_s)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next cycle in which the DUT sees a tick, then returns
    // 1 time unit after the edge that consumed it.
    task automatic next_tick();
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (div_clk && !div_q_tb) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tick_seen", {15'd0, seen}, 16'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  fr10;
        logic [10:0] fr_e;
        logic [10:0] fr_o;
        logic [11:0] fr12;
        bit          saw_done;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_tx",    {15'd0, tx_d},    16'd1);
        chk("rst_ready", {15'd0, ready_d}, 16'd1);
        chk("rst_busy",  {15'd0, busy_d},  16'd0);
        chk("rst_done",  {15'd0, done_d},  16'd0);
        chk("rst_tx_s2", {15'd0, tx_s},    16'd1);
        chk("rst_rdy_pe",{15'd0, ready_pe},16'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- 1. reset mid-frame ----------------
        data_d = 8'h00; valid_d = 1'b1;
        @(posedge clk); #1;
        valid_d = 1'b0;
        chk("t1_busy", {15'd0, busy_d}, 16'd1);
        next_tick();                       // start bit
        chk("t1_start", {15'd0, tx_d}, 16'd0);
        next_tick();                       // data bit 0 (0)
        chk("t1_d0", {15'd0, tx_d}, 16'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t1_async_tx",    {15'd0, tx_d},    16'd1);
        chk("t1_async_ready", {15'd0, ready_d}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done_d) saw_done = 1'b1;
        end
        chk("t1_no_done", {15'd0, saw_done}, 16'd0);
        chk("t1_ready",   {15'd0, ready_d},  16'd1);
        chk("t1_tx_idle", {15'd0, tx_d},     16'd1);

        // ---------------- 2. defaults, 0xA5 ----------------
        @(negedge clk);
        data_d = 8'hA5; valid_d = 1'b1;
        @(posedge clk); #1;
        valid_d = 1'b0;
        chk("t2_ready0", {15'd0, ready_d}, 16'd0);
        chk("t2_wait_tx", {15'd0, tx_d}, 16'd1);
        fr10 = 10'b1_1010_0101_0;          // stop, A5, start (bit 0 first)
        for (int k = 0; k < 10; k++) begin
            next_tick();
            chk("t2_bit", {15'd0, tx_d}, {15'd0, fr10[k]});
            chk("t2_nodone", {15'd0, done_d}, 16'd0);
        end
        next_tick();
        chk("t2_done",  {15'd0, done_d},  16'd1);
        chk("t2_ready", {15'd0, ready_d}, 16'd1);
        @(posedge clk); #1;
        chk("t2_done_pulse", {15'd0, done_d},  16'd0);
        chk("t2_ready_hold", {15'd0, ready_d}, 16'd1);

        // ---------------- 3. parity even / odd, 0xA5 ----------------
        @(negedge clk);
        data_p = 8'hA5; valid_p = 1'b1;
        @(posedge clk); #1;
        valid_p = 1'b0;
        fr_e = 11'b1_0_1010_0101_0;        // even parity of A5 = 0
        fr_o = 11'b1_1_1010_0101_0;        // odd parity of A5 = 1
        for (int k = 0; k < 11; k++) begin
            next_tick();
            chk("t3_even_bit", {15'd0, tx_pe}, {15'd0, fr_e[k]});
            chk("t3_odd_bit",  {15'd0, tx_po}, {15'd0, fr_o[k]});
            chk("t3_nodone",   {14'd0, done_pe, done_po}, 16'd0);
        end
        next_tick();
        chk("t3_done",  {14'd0, done_pe, done_po},   16'd3);
        chk("t3_ready", {14'd0, ready_pe, ready_po}, 16'd3);

        // ---------------- 4. valid held, 0xA5 then 0x3C ----------------
        @(negedge clk);
        data_d = 8'hA5; valid_d = 1'b1;
        @(posedge clk); #1;
        data_d = 8'h3C;                    // valid stays high
        fr10 = 10'b1_1010_0101_0;
        for (int k = 0; k < 10; k++) begin
            next_tick();
            chk("t4_a5_bit", {15'd0, tx_d}, {15'd0, fr10[k]});
            chk("t4_busy",   {15'd0, ready_d}, 16'd0);
        end
        next_tick();
        chk("t4_done", {15'd0, done_d}, 16'd1);
        @(posedge clk); #1;
        chk("t4_accept2", {15'd0, ready_d}, 16'd0);
        chk("t4_gap_tx",  {15'd0, tx_d},    16'd1);
        valid_d = 1'b0;
        fr10 = 10'b1_0011_1100_0;
        for (int k = 0; k < 10; k++) begin
            next_tick();
            chk("t4_3c_bit", {15'd0, tx_d}, {15'd0, fr10[k]});
        end
        next_tick();
        chk("t4_done2", {15'd0, done_d}, 16'd1);

        // ---------------- 5. two stop bits, 0xFF, frozen div_clk ----------------
        @(negedge clk);
        data_s = 8'hFF; valid_s = 1'b1;
        @(posedge clk); #1;
        valid_s = 1'b0;
        fr12 = 12'b11_1111_1111_0;
        for (int k = 0; k < 11; k++) begin
            next_tick();
            chk("t5_bit",    {15'd0, tx_s},   {15'd0, fr12[k]});
            chk("t5_nodone", {15'd0, done_s}, 16'd0);
            if (k == 3) begin
                div_freeze = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    repeat (8) @(posedge clk);
                    #1;
                    chk("t5_frz_tx",    {15'd0, tx_s},    16'd1);
                    chk("t5_frz_ready", {15'd0, ready_s}, 16'd0);
                end
                div_freeze = 1'b0;
            end
        end
        next_tick();
        chk("t5_done",  {15'd0, done_s},  16'd1);
        chk("t5_ready", {15'd0, ready_s}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
